// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the OTTER instruction-fetch stage.
package otter_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC_DEFAULT = 32'd4;
  localparam logic [31:0] ALIGN_MASK     = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Request/acknowledge read bus between the fetch stage and instruction memory.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_wdog.sv
// Fetch watchdog: saturating count of consecutive ack-less wait cycles with a
// sticky timeout flag. A limit of zero disables the flag entirely.
module fetch_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic bus_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      bus_err <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (enable && (count != LIMIT)) begin
        count <= count + 1'b1;
      end
      if ((TIMEOUT_CYCLES != 0) && enable && !clear && (count == LIMIT)) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// OTTER instruction-fetch stage: fetches at the current PC, holds the word for
// decode, and steers the PC register for sequential advance or redirects.
module fetch_unit
  import otter_fetch_pkg::*;
#(
  parameter logic [31:0] PC_INC         = PC_INC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc_count,
  output logic         pc_write,
  output logic [31:0]  pc_din,
  fetch_unit_if.master imem,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc,
  output logic         bus_err
);

  fetch_state_t state, next_state;
  logic [31:0]  req_addr_q;
  logic [31:0]  target;
  logic         wdog_enable;
  logic         wdog_clear;

  // Outputs are gated by rst so nothing reaches the PC register or decode
  // during the reset cycle, even if an ack happens to arrive then.
  always_comb begin
    target          = align_pc(redirect_target);
    next_state      = state;
    pc_write        = 1'b0;
    pc_din          = pc_count + PC_INC;
    imem.imem_req   = 1'b0;
    imem.imem_addr  = req_addr_q;
    if_valid        = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem.imem_req  = 1'b1;
          imem.imem_addr = pc_count;
          if (redirect_valid) begin
            pc_write   = 1'b1;
            pc_din     = target;
            next_state = imem.imem_ack ? FETCH : DRAIN;
          end else if (imem.imem_ack) begin
            next_state = HOLD;
          end
        end
        DRAIN: begin
          imem.imem_req = 1'b1;
          if (redirect_valid) begin
            pc_write = 1'b1;
            pc_din   = target;
          end
          if (imem.imem_ack) begin
            next_state = FETCH;
          end
        end
        HOLD: begin
          if_valid = !redirect_valid;
          if (redirect_valid) begin
            pc_write   = 1'b1;
            pc_din     = target;
            next_state = FETCH;
          end else if (if_ready) begin
            pc_write   = 1'b1;
            pc_din     = if_pc + PC_INC;
            next_state = FETCH;
          end
        end
        default: next_state = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      if_instr   <= '0;
      if_pc      <= '0;
      req_addr_q <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH) begin
        req_addr_q <= pc_count;
        if (imem.imem_ack && !redirect_valid) begin
          if_instr <= imem.imem_rdata;
          if_pc    <= pc_count;
        end
      end
    end
  end

  assign wdog_enable = (state != HOLD) && !imem.imem_ack;
  assign wdog_clear  = imem.imem_ack || (state == HOLD);

  fetch_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .enable  (wdog_enable),
    .clear   (wdog_clear),
    .bus_err (bus_err)
  );

endmodule
